wash_countdown_timer: RTL and testbench
=======================================

# wash_countdown_timer

Countdown timer for washer cycle phases. Holds a remaining-time value in seconds, decrements it once per second while running, and supports start/pause/stop control. `o_remain` drives the 8-bit data input of the 4-digit FND display stage directly, so the panel shows live seconds remaining (0–255). `o_done` is the end-of-phase event for the washer sequencer and the motor control.

## Interface
Parameters:
- `TICK_COUNT`, default 100_000_000: clock cycles per one-second tick (100 MHz system clock). Benches override it with a small value. Minimum is 2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (`i_clk`, `i_reset`).
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  synchronous active-high reset.
- `i_load`  in  1  one-cycle pulse; loads `i_time` into the counter (IDLE/DONE only).
- `i_time`  in  8  preset time in seconds.
- `i_start`  in  1  one-cycle pulse; start from IDLE, or resume from PAUSE.
- `i_pause`  in  1  one-cycle pulse; freeze the countdown.
- `i_stop`  in  1  one-cycle pulse; abort, clear the counter, go to IDLE.
- `o_remain`  out  8  remaining seconds, registered; feeds the display stage.
- `o_state`  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `o_running`  out  1  high while in RUN.
- `o_done`  out  1  one-cycle pulse on entry to DONE.

## Operation
- Reset values: state IDLE, `o_remain`=0, prescaler=0, `o_running`=0, `o_done`=0. Reset overrides all other inputs, including mid-countdown.
- Input priority within one cycle: stop > pause > start > load.
- IDLE:
  - `i_load` → `o_remain`=`i_time`.
  - `i_start` with `o_remain`≠0 → RUN, prescaler=0.
  - `i_start` with `o_remain`=0 → ignored; stay in IDLE.
- RUN:
  - Prescaler counts 0..`TICK_COUNT`-1.
  - At the terminal count, prescaler wraps to 0 and `o_remain` decrements by 1.
  - If that decrement takes `o_remain` from 1 to 0 → DONE, and `o_done`=1 for that single cycle.
  - `i_load` is ignored.
- PAUSE:
  - Prescaler and `o_remain` are frozen.
  - `i_start` → RUN; the prescaler resumes from its held value and is not restarted.
  - `i_load` is ignored.
- DONE:
  - `o_remain` holds at 0.
  - `i_load` → IDLE with `o_remain`=`i_time`.
  - `i_start` is ignored.
- `i_stop` from RUN, PAUSE or DONE → IDLE with `o_remain`=0 and prescaler=0. `i_stop` in IDLE clears `o_remain`.
- `o_remain` never decrements below 0 or wraps; no decrement occurs outside RUN.
- Pause in the same cycle as the terminal prescaler count:
  - Pause wins and the decrement is discarded.
  - The prescaler holds at `TICK_COUNT`-1.
  - The decrement fires on the first RUN cycle after resume.
- Stop in the same cycle as the final decrement: stop wins → IDLE, and `o_done` is not pulsed.

## Timing
- All outputs are registered.
- A control pulse sampled at edge E takes effect in the state/outputs immediately after E.
- First decrement after a start sampled at edge E0 occurs at edge E0+`TICK_COUNT`. Each subsequent decrement follows every `TICK_COUNT` RUN cycles.
- Total RUN time from start to `o_done` = N×`TICK_COUNT` cycles for a loaded value N, excluding paused cycles.
- `o_done` is high for exactly one cycle, aligned with the edge where `o_remain` becomes 0 and `o_state` becomes 3.
- `o_running` equals (`o_state`==RUN) in the same cycle.
- Multi-cycle-high control inputs act as repeated pulses. Upstream must deliver single-cycle pulses (debounced/edge-detected buttons).

## Test plan
1. Reset then idle (`TICK_COUNT`=10), with all control inputs held low → `o_remain`=0, `o_state`=0, `o_done` never asserts.
2. Full countdown:
   - Stimulus: load 3, start at edge E0.
   - Required: `o_remain` shows 2, 1, 0 at E0+10, E0+20, E0+30.
   - Required: `o_done` high only in the cycle after E0+30; state 3.
3. Pause/resume:
   - Stimulus: load 5, start; pause 4 cycles after start; hold 50 cycles; resume.
   - Required: first decrement (5→4) lands exactly 6 RUN cycles after resume.
   - Required: total RUN cycles to done = 50.
4. Pause/tick collision:
   - Stimulus: assert pause exactly on the terminal prescaler cycle.
   - Required: no decrement; on resume, decrement on the first RUN edge.
5. Stop mid-run and at the last tick:
   - Stimulus: stop during RUN → required: IDLE, `o_remain`=0.
   - Stimulus: stop coincident with the 1→0 tick → required: IDLE, no `o_done`.
6. Edge cases:
   - Start with `o_remain`=0 → stays IDLE.
   - Load during RUN → ignored.
   - Load 255 in DONE → IDLE with `o_remain`=255.
   - Reset mid-RUN → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/wash_countdown_timer.sv
// wash_countdown_timer: per-phase countdown for the washer sequencer.
// Holds remaining seconds, decrements once per TICK_COUNT clocks while
// running, and handles start / pause / resume / stop / reload control.
module wash_countdown_timer #(
    parameter int unsigned TICK_COUNT = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [7:0] i_time,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_stop,
    output logic [7:0] o_remain,
    output logic [1:0] o_state,
    output logic       o_running,
    output logic       o_done
);

    localparam int unsigned PRESC_W = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(TICK_COUNT - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [PRESC_W-1:0] prescaler;

    assign o_state = state;

    // Control FSM, one-second prescaler and remaining-time counter.
    // Priority within a cycle: stop > pause > start > load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            prescaler <= '0;
            o_remain  <= '0;
            o_running <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_stop) begin
                        o_remain  <= '0;
                        prescaler <= '0;
                    end else if (i_pause) begin
                        // nothing to freeze while idle
                    end else if (i_start) begin
                        if (o_remain != 8'd0) begin
                            state     <= ST_RUN;
                            prescaler <= '0;
                            o_running <= 1'b1;
                        end
                    end else if (i_load) begin
                        o_remain <= i_time;
                    end
                end

                ST_RUN: begin
                    if (i_stop) begin
                        state     <= ST_IDLE;
                        o_remain  <= '0;
                        prescaler <= '0;
                        o_running <= 1'b0;
                    end else if (i_pause) begin
                        // The pausing cycle is still a RUN cycle, so the
                        // prescaler advances; only at terminal count does it
                        // hold, so the discarded decrement fires on resume.
                        state     <= ST_PAUSE;
                        o_running <= 1'b0;
                        if (prescaler != PRESC_TERM) begin
                            prescaler <= prescaler + PRESC_ONE;
                        end
                    end else if (prescaler == PRESC_TERM) begin
                        prescaler <= '0;
                        if (o_remain != 8'd0) begin
                            o_remain <= o_remain - 8'd1;
                        end
                        if (o_remain <= 8'd1) begin
                            state     <= ST_DONE;
                            o_running <= 1'b0;
                            o_done    <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + PRESC_ONE;
                    end
                end

                ST_PAUSE: begin
                    if (i_stop) begin
                        state     <= ST_IDLE;
                        o_remain  <= '0;
                        prescaler <= '0;
                    end else if (i_pause) begin
                        // already frozen
                    end else if (i_start) begin
                        state     <= ST_RUN;
                        o_running <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (i_stop) begin
                        state     <= ST_IDLE;
                        o_remain  <= '0;
                        prescaler <= '0;
                    end else if (i_pause || i_start) begin
                        // ignored at end of phase
                    end else if (i_load) begin
                        state     <= ST_IDLE;
                        o_remain  <= i_time;
                        prescaler <= '0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    o_remain  <= '0;
                    prescaler <= '0;
                    o_running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_countdown_timer.sv
// tb_wash_countdown_timer: directed-vector bench for wash_countdown_timer
// with TICK_COUNT = 10; expected values are hand-computed edge counts.
`timescale 1ns/1ps
module tb_wash_countdown_timer;

    logic       i_clk;
    logic       i_reset;
    logic       i_load;
    logic [7:0] i_time;
    logic       i_start;
    logic       i_pause;
    logic       i_stop;
    logic [7:0] o_remain;
    logic [1:0] o_state;
    logic       o_running;
    logic       o_done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned done_seen;

    wash_countdown_timer #(
        .TICK_COUNT(10)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (i_load),
        .i_time   (i_time),
        .i_start  (i_start),
        .i_pause  (i_pause),
        .i_stop   (i_stop),
        .o_remain (o_remain),
        .o_state  (o_state),
        .o_running(o_running),
        .o_done   (o_done)
    );

    // 100 MHz-style free-running clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle 1 ns past it
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) tick();
    endtask

    initial begin
        i_reset = 1'b1;
        i_load  = 1'b0;
        i_time  = 8'd0;
        i_start = 1'b0;
        i_pause = 1'b0;
        i_stop  = 1'b0;
        ticks(2);
        i_reset = 1'b0;

        // 1. reset then idle
        check_eq("rst_remain", o_remain, 0);
        check_eq("rst_state", o_state, 0);
        check_eq("rst_running", o_running, 0);
        done_seen = 0;
        for (int unsigned k = 0; k < 20; k++) begin
            tick();
            if (o_done) done_seen++;
        end
        check_eq("idle_no_done", done_seen, 0);
        check_eq("idle_remain", o_remain, 0);

        // 2. full countdown of 3
        i_time = 8'd3; i_load = 1'b1; tick(); i_load = 1'b0;
        check_eq("load3_remain", o_remain, 3);
        i_start = 1'b1; tick(); i_start = 1'b0;            // E0
        check_eq("start_state", o_state, 1);
        check_eq("start_running", o_running, 1);
        ticks(9);                                           // E0+9
        check_eq("e9_remain", o_remain, 3);
        tick();                                             // E0+10
        check_eq("e10_remain", o_remain, 2);
        ticks(10);                                          // E0+20
        check_eq("e20_remain", o_remain, 1);
        ticks(9);                                           // E0+29
        check_eq("e29_done", o_done, 0);
        tick();                                             // E0+30
        check_eq("e30_remain", o_remain, 0);
        check_eq("e30_state", o_state, 3);
        check_eq("e30_done", o_done, 1);
        check_eq("e30_running", o_running, 0);
        tick();
        check_eq("e31_done", o_done, 0);
        check_eq("e31_state", o_state, 3);

        // 3. pause/resume, load 5 from DONE
        i_time = 8'd5; i_load = 1'b1; tick(); i_load = 1'b0;
        check_eq("reload5_state", o_state, 0);
        check_eq("reload5_remain", o_remain, 5);
        i_start = 1'b1; tick(); i_start = 1'b0;            // E0
        ticks(3);
        i_pause = 1'b1; tick(); i_pause = 1'b0;            // E0+4
        check_eq("pause_state", o_state, 2);
        check_eq("pause_running", o_running, 0);
        ticks(50);
        check_eq("paused_remain", o_remain, 5);
        check_eq("paused_state", o_state, 2);
        i_start = 1'b1; tick(); i_start = 1'b0;            // R
        check_eq("resume_state", o_state, 1);
        ticks(5);                                           // R+5
        check_eq("r5_remain", o_remain, 5);
        tick();                                             // R+6
        check_eq("r6_remain", o_remain, 4);
        ticks(39);                                          // R+45
        check_eq("r45_remain", o_remain, 1);
        check_eq("r45_done", o_done, 0);
        tick();                                             // R+46: 50 RUN cycles total
        check_eq("r46_done", o_done, 1);
        check_eq("r46_state", o_state, 3);

        // 4. pause on terminal prescaler cycle, then stop on 1->0 tick
        i_time = 8'd2; i_load = 1'b1; tick(); i_load = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;            // E0
        ticks(9);                                           // E0+9, prescaler at terminal
        check_eq("coll_pre_remain", o_remain, 2);
        i_pause = 1'b1; tick(); i_pause = 1'b0;            // E0+10
        check_eq("coll_remain", o_remain, 2);
        check_eq("coll_state", o_state, 2);
        ticks(3);
        check_eq("coll_hold_remain", o_remain, 2);
        i_start = 1'b1; tick(); i_start = 1'b0;            // R
        check_eq("coll_resume_remain", o_remain, 2);
        tick();                                             // R+1
        check_eq("coll_r1_remain", o_remain, 1);
        ticks(9);                                           // R+10
        check_eq("stoplast_pre_remain", o_remain, 1);
        i_stop = 1'b1; tick(); i_stop = 1'b0;              // R+11 final tick
        check_eq("stoplast_state", o_state, 0);
        check_eq("stoplast_remain", o_remain, 0);
        check_eq("stoplast_done", o_done, 0);
        tick();
        check_eq("stoplast_done2", o_done, 0);

        // 5. stop mid-run
        i_time = 8'd7; i_load = 1'b1; tick(); i_load = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        ticks(15);
        check_eq("mid_remain", o_remain, 6);
        i_stop = 1'b1; tick(); i_stop = 1'b0;
        check_eq("stop_state", o_state, 0);
        check_eq("stop_remain", o_remain, 0);
        check_eq("stop_running", o_running, 0);

        // 6. edge cases
        i_start = 1'b1; tick(); i_start = 1'b0;
        check_eq("start0_state", o_state, 0);
        i_time = 8'd4; i_load = 1'b1; tick(); i_load = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;            // E0
        i_time = 8'd200; i_load = 1'b1; tick(); i_load = 1'b0; // E0+1
        check_eq("runload_remain", o_remain, 4);
        check_eq("runload_state", o_state, 1);
        ticks(39);                                          // E0+40
        check_eq("e40_done", o_done, 1);
        check_eq("e40_state", o_state, 3);
        i_start = 1'b1; tick(); i_start = 1'b0;
        check_eq("donestart_state", o_state, 3);
        check_eq("donestart_remain", o_remain, 0);
        i_time = 8'd255; i_load = 1'b1; tick(); i_load = 1'b0;
        check_eq("load255_state", o_state, 0);
        check_eq("load255_remain", o_remain, 255);
        i_start = 1'b1; tick(); i_start = 1'b0;
        ticks(15);
        check_eq("r255_remain", o_remain, 254);
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        check_eq("midrst_remain", o_remain, 0);
        check_eq("midrst_state", o_state, 0);
        check_eq("midrst_running", o_running, 0);
        check_eq("midrst_done", o_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
